// File: rtl/axis_uart_rx.sv
// axis_uart_rx: UART receiver (8N1, even parity under UART_PARITY_EN) delivering bytes as AXI-Stream beats
module axis_uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       parity_err_o
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`ifdef UART_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
  logic par_bad;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state, state_nxt;
  logic rx_m, rx_s;
  logic [CNT_W-1:0] timer;
  logic [2:0] idx;
  logic [7:0] shreg;
  logic counting, tick, deliver, frame_bad;
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_i;
      rx_s <= rx_m;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      state_nxt = rx_s ? IDLE : START;
      START:     state_nxt = tick ? (rx_s ? IDLE : DATA) : START;
      DATA:      state_nxt = (tick && idx == 3'd7) ? AFTER_DATA : DATA;
`ifdef UART_PARITY_EN
      PARITY:    state_nxt = tick ? STOP : PARITY;
`endif
      STOP:      state_nxt = tick ? (rx_s ? IDLE : WAIT_IDLE) : STOP;
      WAIT_IDLE: state_nxt = rx_s ? IDLE : WAIT_IDLE;
      default:   state_nxt = IDLE;
    endcase
  end
  // START samples at half a bit so every later sample lands mid-bit
  always_comb begin
    counting = state inside {START, DATA, PARITY, STOP};
    tick = counting && timer == ((state == START) ? CNT_W'(CLKS_PER_BIT / 2 - 1) : CNT_W'(CLKS_PER_BIT - 1));
    deliver = state == STOP && tick && rx_s;
    frame_bad = state == STOP && tick && !rx_s;
  end
  always_ff @(posedge clk) begin
    if (rst || tick || state != state_nxt) timer <= '0;
    else if (counting) timer <= timer + CNT_W'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      shreg <= '0;
      m_axis_tdata <= '0;
      m_axis_tvalid <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      if (state == START) idx <= '0;
      if (state == DATA && tick) begin
        shreg <= {rx_s, shreg[7:1]};
        idx <= idx + 3'd1;
      end
      if (deliver && (!m_axis_tvalid || m_axis_tready)) begin
        m_axis_tdata <= shreg;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) m_axis_tvalid <= 1'b0;
      frame_err_o <= frame_bad;
      overrun_o <= deliver && m_axis_tvalid && !m_axis_tready;
    end
  end
`ifdef UART_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_bad <= 1'b0;
      parity_err_o <= 1'b0;
    end else begin
      if (state == PARITY && tick) par_bad <= ^{shreg, rx_s};
      parity_err_o <= deliver && par_bad;
    end
  end
`else
  assign parity_err_o = 1'b0;
`endif
endmodule
